// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the round-robin PipeIn arbiter.
//   DEFAULT_W : default payload width (PipeIn_OC_3, 32 + 64 bits)
//   MAX_N     : largest supported producer count
//   clog2     : ceiling log2, used to size the grant/pointer fields
//   rr_pick   : rotating first-set search over the slot occupancy flags
package pipe_arb_pkg;

  localparam int DEFAULT_W = 96;
  localparam int MAX_N     = 16;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  // First index with full[] set, scanning ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
  // Returns 0 when nothing is set; callers gate on any-full separately.
  function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] full,
                                         input logic [3:0]       ptr,
                                         input int               n);
    logic [3:0] pick;
    logic       found;
    logic [4:0] sum;
    pick  = 4'd0;
    found = 1'b0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n) begin
        // ptr < n and k < n, so one subtraction brings the sum back into range
        sum = {1'b0, ptr} + 5'(k);
        if (sum >= 5'(n)) begin
          sum = sum - 5'(n);
        end else begin
          sum = sum;
        end
        if (!found && full[sum[3:0]]) begin
          pick  = sum[3:0];
          found = 1'b1;
        end else begin
          found = found;
        end
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/pipe_in_slot.sv
// One-entry holding slot for a single upstream PipeIn producer.
//   CLK, RST  : clock, synchronous active-high reset
//   enq__ENA  : producer enqueue strobe (honoured only while enq__RDY is high)
//   enq_v     : producer payload
//   deq       : arbiter is forwarding this slot this cycle
//   enq__RDY  : producer guard, high while the slot is empty and not in reset
//   full      : slot occupancy
//   data      : buffered payload
module pipe_in_slot
  import pipe_arb_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         enq__ENA,
  input  logic [W-1:0] enq_v,
  input  logic         deq,
  output logic         enq__RDY,
  output logic         full,
  output logic [W-1:0] data
);

  logic         full_q;
  logic         full_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign enq__RDY = !full_q && !RST;
  assign full     = full_q;
  assign data     = data_q;

  // Next slot state: capture only into an empty slot, drain on deq.
  // A slot being drained is full, so its RDY is low and the two never coincide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (enq__ENA && enq__RDY) begin
      full_d = 1'b1;
      data_d = enq_v;
    end else if (deq) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Slot register with synchronous reset discarding any buffered word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/pipe_in_arbiter.sv
// Round-robin arbiter sharing one downstream PipeIn enq port between N producers.
//   CLK, RST      : clock, synchronous active-high reset
//   in_enq__ENA   : per-producer enqueue strobes
//   in_enq_v      : producer i payload at [i*W +: W]
//   in_enq__RDY   : per-producer guards (slot empty, not in reset)
//   out_enq__ENA  : enqueue to the shared sink
//   out_enq_v     : forwarded payload (0 when no slot is full)
//   out_enq__RDY  : sink guard
//   grant         : index of the forwarded slot, meaningful while out_enq__ENA is high
// Outputs depend only on registered slot state, ptr, RST and out_enq__RDY;
// no in_enq__ENA reaches an output combinationally.
module pipe_in_arbiter
  import pipe_arb_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = DEFAULT_W,
  localparam int PW = clog2(N)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   in_enq__ENA,
  input  logic [N*W-1:0] in_enq_v,
  output logic [N-1:0]   in_enq__RDY,
  output logic           out_enq__ENA,
  output logic [W-1:0]   out_enq_v,
  input  logic           out_enq__RDY,
  output logic [PW-1:0]  grant
);

  logic [N-1:0]  full_s;
  logic [N-1:0]  deq_s;
  logic [W-1:0]  data_s [N];
  logic [PW-1:0] pick_s;
  logic          any_full_s;
  logic          xfer_s;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  for (genvar i = 0; i < N; i++) begin : g_slot
    pipe_in_slot #(.W(W)) u_slot (
      .CLK      (CLK),
      .RST      (RST),
      .enq__ENA (in_enq__ENA[i]),
      .enq_v    (in_enq_v[i*W +: W]),
      .deq      (deq_s[i]),
      .enq__RDY (in_enq__RDY[i]),
      .full     (full_s[i]),
      .data     (data_s[i])
    );
    assign deq_s[i] = xfer_s && (pick_s == PW'(i));
  end

  assign any_full_s = |full_s;
  assign pick_s     = PW'(rr_pick(16'(full_s), 4'(ptr_q), N));
  assign xfer_s     = any_full_s && out_enq__RDY && !RST;

  // Output drive: payload and grant are forced to 0 when nothing is buffered.
  always_comb begin
    out_enq__ENA = xfer_s;
    if (any_full_s && !RST) begin
      out_enq_v = data_s[pick_s];
      grant     = pick_s;
    end else begin
      out_enq_v = '0;
      grant     = '0;
    end
  end

  // Pointer advances past the slot just forwarded, so it has lowest priority next.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_s) begin
      if (int'(pick_s) == N - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_s + PW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: tb/tb_pipe_in_arbiter.sv
// Scoreboard bench for pipe_in_arbiter: a driver updates a slot/queue model and
// pushes each expected transfer; a negedge monitor pops and compares.
module tb_pipe_in_arbiter;
  import pipe_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 96;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_ena;
  logic [N*W-1:0] in_v;
  logic [N-1:0]   in_rdy;
  logic           out_ena;
  logic [W-1:0]   out_v;
  logic           out_rdy;
  logic [PW-1:0]  grant;

  always #5 clk = ~clk;

  pipe_in_arbiter #(.N(N), .W(W)) dut (
    .CLK          (clk),
    .RST          (rst),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_ena),
    .out_enq_v    (out_v),
    .out_enq__RDY (out_rdy),
    .grant        (grant)
  );

  typedef struct packed {
    logic [PW-1:0] g;
    logic [W-1:0]  v;
  } xfer_t;

  // reference model: occupancy, payload per slot, rotating pointer
  bit           m_full [N];
  logic [W-1:0] m_data [N];
  int           m_ptr;

  xfer_t        exp_q [$];
  xfer_t        mon_e;
  logic [N-1:0] exp_rdy;
  bit           exp_idle;
  bit           chk_en = 1'b0;
  int           checks = 0;
  int           failures = 0;

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] r;
    for (int i = 0; i < (N * W) / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle of stimulus; the model decides this cycle's transfer and next state.
  task automatic step(input logic r, input logic [N-1:0] ena_req,
                      input logic [N*W-1:0] v, input logic sink);
    logic [N-1:0] ena;
    int g;
    bit any;
    xfer_t e;
    ena = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!r && !m_full[i]) ena[i] = ena_req[i];
      if (m_full[i]) any = 1'b1;
      exp_rdy[i] = !r && !m_full[i];
    end
    rst = r; in_ena = ena; in_v = v; out_rdy = sink;
    exp_idle = r || !any;
    g = -1;
    if (!r && any && sink) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && m_full[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      e.g = PW'(g);
      e.v = m_data[g];
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_ptr = 0;
    end else begin
      if (g >= 0) begin
        m_full[g] = 1'b0;
        m_ptr = (g + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (ena[i]) begin
          m_full[i] = 1'b1;
          m_data[i] = v[i*W +: W];
        end
    end
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares guards every cycle and each presented transfer against the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (in_rdy !== exp_rdy) begin
        failures++;
        $display("FAIL in_rdy actual=%b required=%b t=%0t", in_rdy, exp_rdy, $time);
      end
      if (out_ena === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ena actual grant=%0d v=%h required no transfer t=%0t",
                   grant, out_v, $time);
        end else begin
          mon_e = exp_q.pop_front();
          if (grant !== mon_e.g || out_v !== mon_e.v) begin
            failures++;
            $display("FAIL xfer actual grant=%0d v=%h required grant=%0d v=%h t=%0t",
                     grant, out_v, mon_e.g, mon_e.v, $time);
          end
        end
      end else begin
        if (exp_q.size() != 0) begin
          checks++;
          failures++;
          mon_e = exp_q.pop_front();
          $display("FAIL missing_xfer actual ena=%b required grant=%0d v=%h t=%0t",
                   out_ena, mon_e.g, mon_e.v, $time);
        end
        if (exp_idle) begin
          checks++;
          if (out_v !== '0 || grant !== '0 || out_ena !== 1'b0) begin
            failures++;
            $display("FAIL idle actual ena=%b grant=%0d v=%h required 0/0/0 t=%0t",
                     out_ena, grant, out_v, $time);
          end
        end
      end
    end
  end

  // Producers must never strobe ENA while their guard is low.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < N; i++)
        assert (!(in_ena[i] && !in_rdy[i]))
          else $error("protocol violation on producer %0d", i);
    end
  end

  initial begin
    logic [N*W-1:0] vec;
    rst = 1'b1; in_ena = '0; in_v = '0; out_rdy = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;

    // reset held three cycles, then idle
    repeat (3) step(1'b1, '0, '0, 1'b1);
    repeat (10) step(1'b0, '0, '0, 1'b1);

    // round robin: all four slots in one cycle, values 10..13
    vec = '0;
    for (int i = 0; i < N; i++) vec[i*W +: W] = W'(10 + i);
    step(1'b0, 4'b1111, vec, 1'b1);
    repeat (5) step(1'b0, '0, '0, 1'b1);

    // back-pressure: slots 1 and 3 held for 5 cycles, then drained 1 then 3
    step(1'b0, 4'b1010, rand_vec(), 1'b0);
    repeat (5) step(1'b0, '0, '0, 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1);

    // single producer 2 sends 0xA5 (leaves ptr at 3)
    vec = '0;
    vec[2*W +: W] = 96'hA5;
    step(1'b0, 4'b0100, vec, 1'b1);
    repeat (2) step(1'b0, '0, '0, 1'b1);

    // pointer wrap: ptr=3, slots 0 and 3 full -> grant 3 then 0
    step(1'b0, 4'b1001, rand_vec(), 1'b0);
    repeat (3) step(1'b0, '0, '0, 1'b1);

    // reset mid-run with three slots full
    step(1'b0, 4'b0111, rand_vec(), 1'b0);
    step(1'b1, '0, '0, 1'b1);
    repeat (2) step(1'b0, '0, '0, 1'b1);

    // randomized traffic with random sink stalls and rare resets
    repeat (500) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           N'($urandom), rand_vec(),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    repeat (6) step(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_in_arbiter.md
# pipe_in_arbiter

Round-robin arbiter that shares one downstream `PipeIn` enq port between `N` upstream `PipeIn` producers. Typical producers are several `EchoIndicationOutput`-style serializers; the shared sink is a single NOC/indication pipe. Each producer lands in its own one-entry slot, and the arbiter forwards at most one slot per cycle in fair rotating order. All guards follow the atomicc rule: `__RDY` is independent of the same-cycle `__ENA`, and `__ENA` is only asserted while the partner's `__RDY` is high.

## Interface
Parameters:
- `N`, default 4: number of upstream producers, 2..16.
- `W`, default 96: payload width in bits. 96 is `PipeIn_OC_3` (32 + 64).

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: synchronous reset, active-high.
- `in$enq__ENA` in N: per-producer enqueue strobe.
- `in$enq$v` in N*W: producer `i` occupies bits `[i*W +: W]`.
- `in$enq__RDY` out N: per-producer guard.
- `out$enq__ENA` out 1: enqueue to the shared sink.
- `out$enq$v` out W: forwarded payload.
- `out$enq__RDY` in 1: sink guard.
- `grant` out clog2(N): index of the slot being forwarded. Valid only while `out$enq__ENA` is high.

## Operation
- State:
  - `full[N]`: slot occupancy flags.
  - `data[N][W]`: slot payloads.
  - `ptr`: round-robin pointer, clog2(N) bits.
- Input guard: `in$enq__RDY[i] = !full[i] && !RST`.
- Capture: when `in$enq__ENA[i]` is high and `in$enq__RDY[i]` is high:
  - `data[i] <= in$enq$v` slice `i`.
  - `full[i] <= 1`.
- Protocol violation: an ENA while RDY is low is ignored and leaves no state change. The bench flags it as an assertion failure.
- Grant (combinational): `g` = the first index with `full` set, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1`.
- Output drive:
  - `out$enq__ENA = |full && out$enq__RDY && !RST`.
  - `out$enq$v = data[g]` and `grant = g`.
  - When no slot is full, `out$enq$v` and `grant` hold 0.
- On transfer (`out$enq__ENA` high):
  - `full[g] <= 0`.
  - `ptr <= (g+1) mod N`.
- Without a transfer, `ptr` holds.
- Simultaneous events:
  - A slot being forwarded cannot be refilled in the same cycle, because its RDY was already low.
  - Captures into other slots proceed in parallel with a transfer.
- Sink back-pressure: while `out$enq__RDY` is low, all slots and `ptr` hold. Captures into empty slots still occur.
- Payload is forwarded unmodified. No reordering happens within one producer, since each slot has depth 1.

## Timing
- Reset values, all driven while `RST` is high and on the first cycle after it:
  - `full = 0` and `ptr = 0`.
  - `in$enq__RDY = 0` during reset, then all-ones on the first cycle after reset.
  - `out$enq__ENA = 0`, `out$enq$v = 0`, `grant = 0`.
- Reset asserted mid-operation discards all buffered entries and does not drain them.
- Latency: data captured at edge `t` is presented with `out$enq__ENA` in cycle `t+1`, at the earliest.
- Throughput:
  - Per producer: 1 word per 2 cycles (slot full → forwarded → RDY again).
  - Aggregate: 1 word per cycle when ≥2 slots are active and the sink is always ready.
- Fairness: with all N slots continuously full and the sink ready, grants run 0,1,…,N-1,0,…. No producer waits more than N-1 transfers.
- `out$enq__ENA` and `grant` are combinational from registered `full`/`ptr` and from `out$enq__RDY`. There is no combinational path from any `in$enq__ENA` to any output.

## Structure
- Shared package `pipe_arb_pkg` holds:
  - the localparam default `W = 96`.
  - a `clog2` helper.
  - the function `rr_pick(full, ptr)`, which returns the next index.
- Sub-module `pipe_in_slot`: one per producer, instantiated N times. It contains one register stage with:
  - inputs `enq__ENA`, `enq$v`, `deq`.
  - outputs `enq__RDY`, `full`, `data`.
- The top level holds `ptr`, the grant mux and the output drive.

## Test plan
- Reset/idle: hold `RST` 3 cycles, then release; no stimulus → `in$enq__RDY = 4'b1111`, `out$enq__ENA = 0`, `out$enq$v = 0` for 10 cycles.
- Single producer: `in` 2 sends `0xA5` at cycle 5, sink ready → `out$enq__ENA` at cycle 6 with `v = 0xA5`, `grant = 2`; `in$enq__RDY[2]` is low in cycle 6 and high in cycle 7.
- Round robin: fill all 4 slots in one cycle with values 10..13, sink ready → outputs 10,11,12,13 in consecutive cycles with `grant` 0,1,2,3; then `ptr = 0`.
- Back-pressure: slots 1 and 3 full, sink RDY low for 5 cycles → no ENA, slots hold. RDY then goes high → outputs slot 1 then slot 3.
- Pointer wrap: `ptr = 3`, slots 0 and 3 full → grant 3 first, then 0.
- Reset mid-run: 3 slots full, assert `RST` 1 cycle → all slots empty; next cycle `out$enq__ENA = 0` and `in$enq__RDY = 4'b1111`.
